// File: rtl/seq_mon_pkg.sv
// seq_mon_pkg: shared state encoding and saturating-add helper for seq_match_monitor
//   S_IDLE / S_RUN : monitor FSM states
//   sat_add        : acc + inc, clamped at 2**cnt_w-1 (operates on 32-bit carriers)
package seq_mon_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic inc, input int cnt_w);
        logic [32:0] max_v;
        max_v = (33'd1 << cnt_w) - 33'd1;
        return (inc && ({1'b0, acc} < max_v)) ? acc + 32'd1 : acc;
    endfunction

endpackage

// File: rtl/win_timer.sv
// win_timer: window-cycle counter for seq_match_monitor
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   run  in  count while high; clears the timer when low
//   last out high on the final cycle of a window (timer == WIN_LEN-1)
module win_timer #(
    parameter int WIN_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic last
);

    localparam int TW = $clog2(WIN_LEN);

    logic [TW-1:0] timer_q, timer_d;

    // The window ends on an explicit compare, so non-power-of-two lengths
    // never rely on the counter wrapping.
    always_comb begin
        last    = timer_q == TW'(WIN_LEN - 1);
        timer_d = (!run || last) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
    end

endmodule

// File: rtl/seq_match_monitor.sv
// seq_match_monitor: counts detector match pulses over back-to-back windows,
// publishes each window's count and keeps sticky alarm / saturation flags
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   monitoring enable (level)
//   det        in   1-clk match pulse from the sequence detector
//   clr        in   clears alarm and sat (a same-cycle set wins)
//   count_out  out  match count of the last completed window
//   win_done   out  1-clk pulse when count_out is updated
//   alarm      out  sticky: some window count reached THRESH
//   sat        out  sticky: accumulator saturated in some window
//   busy       out  high while the monitor is running
module seq_match_monitor
    import seq_mon_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int THRESH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             det,
    input  logic             clr,
    output logic [CNT_W-1:0] count_out,
    output logic             win_done,
    output logic             alarm,
    output logic             sat,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d, count_q, count_d, final_cnt;
    logic             win_done_q, win_done_d;
    logic             alarm_q, alarm_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             run, tmr_run, last, close, set_sat;

    // Dropping en mid-window clears the timer on the same edge the FSM
    // leaves RUN, so the timer is already 0 throughout IDLE.
    assign tmr_run = run && en;

    win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (tmr_run),
        .last (last)
    );

    always_comb begin
        run        = state_q == S_RUN;
        state_d    = en ? S_RUN : S_IDLE;
        final_cnt  = CNT_W'(sat_add(32'(acc_q), det, CNT_W));
        close      = run && last;
        set_sat    = run && det && (acc_q == '1);
        // A closing cycle completes even with en low; the accumulator then
        // restarts from 0 (next window or IDLE).
        acc_d      = (tmr_run && !last) ? final_cnt : '0;
        count_d    = close ? final_cnt : count_q;
        win_done_d = close;
        alarm_d    = (close && (final_cnt >= CNT_W'(THRESH))) || (alarm_q && !clr);
        sat_d      = set_sat || (sat_q && !clr);
        busy_d     = state_d == S_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            win_done_q <= 1'b0;
            alarm_q    <= 1'b0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            win_done_q <= win_done_d;
            alarm_q    <= alarm_d;
            sat_q      <= sat_d;
            busy_q     <= busy_d;
        end
    end

    assign count_out = count_q;
    assign win_done  = win_done_q;
    assign alarm     = alarm_q;
    assign sat       = sat_q;
    assign busy      = busy_q;

endmodule
